branch_unit: RTL
================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter WID_DATA, default 32, operand width.
REQ-002 SHALL have parameter WID_PC, default 32, program-counter width.
REQ-003 SHALL have parameter WID_CNT, default 16, mispredict counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  branch operands valid this cycle.
REQ-007 SHALL have port stall  input  1  downstream stall; hold all output registers.
REQ-008 SHALL have port flush  input  1  kill the in-flight and incoming branch.
REQ-009 SHALL have port funct3  input  3  branch condition select.
REQ-010 SHALL have port dataA, dataB  input  WID_DATA  compare operands.
REQ-011 SHALL have port pc, target  input  WID_PC  branch PC and taken target.
REQ-012 SHALL have port pred_taken  input  1  front-end prediction.
REQ-013 SHALL have port cnt_clr  input  1  synchronous clear of mispred_cnt.
REQ-014 SHALL have port out_valid  output  1  registered result valid.
REQ-015 SHALL have port taken, mispredict, illegal  output  1 each  registered resolution flags.
REQ-016 SHALL have port br_eq, br_lt  output  1 each  registered compare flags; br_lt signedness set by funct3.
REQ-017 SHALL have port redirect_pc  output  WID_PC  registered correct next PC.
REQ-018 SHALL have port mispred_cnt  output  WID_CNT  saturating mispredict count.

Function
REQ-019 SHALL define accept = in_valid & ~stall & ~flush.
REQ-020 SHALL compute br_eq = (dataA == dataB) and br_lt as a signed compare for funct3 100/101 and an unsigned compare for all other codes.
REQ-021 SHALL decode taken: 000 BEQ br_eq; 001 BNE ~br_eq; 100 BLT br_lt; 101 BGE ~br_lt; 110 BLTU br_lt; 111 BGEU ~br_lt.
REQ-022 SHALL treat funct3 010/011 as illegal: taken=0, illegal=1, mispredict=0, redirect_pc=pc+4.
REQ-023 SHALL compute redirect_pc = taken ? target : pc+4, with the addition modulo 2^WID_PC (wrap-around, no carry out).
REQ-024 SHALL compute mispredict = (taken != pred_taken) for legal codes.
REQ-025 SHALL have a latency of one cycle: on an accept edge all result registers load and out_valid=1 in the following cycle.
REQ-026 SHALL hold out_valid and all result registers unchanged while stall=1 and flush=0.
REQ-027 SHALL clear out_valid on any edge with flush=1, regardless of stall or in_valid; the other result registers are don't-care while out_valid=0.
REQ-028 SHALL clear out_valid on an edge with stall=0, flush=0 and in_valid=0.
REQ-029 SHALL increment mispred_cnt by 1 only on an accept edge whose computed mispredict=1; a held (stalled) result SHALL NOT recount.
REQ-030 SHALL saturate mispred_cnt at 2^WID_CNT-1.
REQ-031 SHALL give cnt_clr priority over increment: the count becomes 0 on that edge, and a same-edge mispredict is lost.
REQ-032 SHALL hold the output pins at their registered values; they SHALL be qualified only by out_valid.

Reset
REQ-033 SHALL, on an edge with rst=1, set out_valid, taken, mispredict, illegal, br_eq, br_lt to 0, redirect_pc to 0 and mispred_cnt to 0.
REQ-034 SHALL give rst priority over flush, stall, cnt_clr and accept; a branch arriving during reset SHALL be discarded.

Verification
REQ-035 SHALL cover a signed BLT: funct3=100, dataA=0xFFFFFFFF, dataB=1, pc=0x100, target=0x200, pred_taken=0 -> next cycle out_valid=1, taken=1, br_lt=1, mispredict=1, redirect_pc=0x200, mispred_cnt=1.
REQ-036 SHALL cover an unsigned BLTU not taken: funct3=110, same operands, pc=0x100, pred_taken=0 -> taken=0, br_lt=0, mispredict=0, redirect_pc=0x104, count unchanged.
REQ-037 SHALL cover a stall hold: a result with mispredict=1, then stall=1 for 3 cycles with new in_valid -> outputs frozen and mispred_cnt incremented exactly once.
REQ-038 SHALL cover flush and stall together: flush=1 with stall=1 and in_valid=1 -> out_valid=0 next cycle and no count change.
REQ-039 SHALL cover saturation and clear: WID_CNT=2 with 5 mispredicting accepts -> mispred_cnt=3; cnt_clr=1 on the edge of a 6th mispredict -> mispred_cnt=0.
REQ-040 SHALL cover illegal code and wrap: funct3=010, pc=0xFFFFFFFC -> illegal=1, taken=0, redirect_pc=0x00000000; rst=1 mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/branch_unit.sv
// Branch resolution stage: compares operands, decodes the condition, and registers
// the taken/mispredict/redirect result one cycle later, with a saturating mispredict count.
module branch_unit #(
  parameter int WID_DATA = 32,
  parameter int WID_PC   = 32,
  parameter int WID_CNT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic [2:0]          funct3,
  input  logic [WID_DATA-1:0] dataA,
  input  logic [WID_DATA-1:0] dataB,
  input  logic [WID_PC-1:0]   pc,
  input  logic [WID_PC-1:0]   target,
  input  logic                pred_taken,
  input  logic                cnt_clr,
  output logic                out_valid,
  output logic                taken,
  output logic                mispredict,
  output logic                illegal,
  output logic                br_eq,
  output logic                br_lt,
  output logic [WID_PC-1:0]   redirect_pc,
  output logic [WID_CNT-1:0]  mispred_cnt
);

  typedef struct packed {
    logic              taken;
    logic              mispredict;
    logic              illegal;
    logic              br_eq;
    logic              br_lt;
    logic [WID_PC-1:0] redirect_pc;
  } res_t;

  res_t res_c, res_q;
  logic accept, signed_cmp;

  assign accept     = in_valid & ~stall & ~flush;
  assign signed_cmp = (funct3[2:1] == 2'b10);

  always_comb begin
    res_c         = '0;
    res_c.br_eq   = (dataA == dataB);
    res_c.br_lt   = signed_cmp ? ($signed(dataA) < $signed(dataB)) : (dataA < dataB);
    res_c.illegal = (funct3[2:1] == 2'b01);
    case (funct3)
      3'b000:  res_c.taken = res_c.br_eq;
      3'b001:  res_c.taken = ~res_c.br_eq;
      3'b100,
      3'b110:  res_c.taken = res_c.br_lt;
      3'b101,
      3'b111:  res_c.taken = ~res_c.br_lt;
      default: res_c.taken = 1'b0;
    endcase
    res_c.mispredict  = ~res_c.illegal & (res_c.taken != pred_taken);
    // pc+4 wraps modulo 2^WID_PC; the carry is simply dropped
    res_c.redirect_pc = res_c.taken ? target : pc + WID_PC'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) res_q <= res_c;
    end
  end

  // Count only fresh accepts, so a result held under stall is never recounted
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      mispred_cnt <= '0;
    else if (accept && res_c.mispredict && (mispred_cnt != {WID_CNT{1'b1}}))
      mispred_cnt <= mispred_cnt + WID_CNT'(1);
  end

  assign taken       = res_q.taken;
  assign mispredict  = res_q.mispredict;
  assign illegal     = res_q.illegal;
  assign br_eq       = res_q.br_eq;
  assign br_lt       = res_q.br_lt;
  assign redirect_pc = res_q.redirect_pc;

endmodule
